// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the unified memory port arbiter.
// State encoding, requester IDs and default sizing live here.
package mem_port_arbiter_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_STARVE_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_WAIT = 2'd1,
      ST_D_WAIT  = 2'd2
   } arbStateT;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   function automatic logic [3:0] satInc(
      input logic [3:0] cnt,
      input logic [3:0] lim
   );
      return (cnt >= lim) ? lim : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory handshakes around the arbiter.
// master is the arbiter view, slave is the surrounding core/memory.
interface mem_port_arbiter_if #(
   parameter int WIDTH = 32
);

   logic             if_req;
   logic [WIDTH-1:0] if_addr;
   logic [WIDTH-1:0] if_rdata;
   logic             if_ack;

   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic [WIDTH-1:0] d_rdata;
   logic             d_ack;

   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ready;

   logic             stall;
   logic             busy;

   modport master (
      input  if_req, if_addr,
      output if_rdata, if_ack,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ack,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output stall, busy
   );

   modport slave (
      output if_req, if_addr,
      input  if_rdata, if_ack,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ack,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  stall, busy
   );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant selection between fetch and data requesters.
// Data wins unless fetch has been passed over STARVE_MAX times.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic       ifReq,
   input  logic       dReq,
   input  logic       ifMask,
   input  logic       dMask,
   input  logic [3:0] starveCnt,
   output logic       grantValid,
   output logic       grantId
);

   logic ifLive;
   logic dLive;
   logic forceIf;

   // A requester acked this cycle still shows its old req; ignore it.
   assign ifLive  = ifReq & ~ifMask;
   assign dLive   = dReq & ~dMask;
   assign forceIf = ifLive && (starveCnt == 4'(STARVE_MAX));

   always_comb begin
      grantValid = ifLive | dLive;
      grantId    = REQ_IF;
      unique case (1'b1)
         forceIf:           grantId = REQ_IF;
         dLive && !forceIf: grantId = REQ_D;
         default:           grantId = REQ_IF;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction at a time, one-cycle ack, combinational stall.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);

   arbStateT         state;
   logic [3:0]       starveCnt;
   logic             grantValid;
   logic             grantId;

   logic             memReqQ;
   logic             memWeQ;
   logic [WIDTH-1:0] memAddrQ;
   logic [WIDTH-1:0] memWdataQ;
   logic             ifAckQ;
   logic [WIDTH-1:0] ifRdataQ;
   logic             dAckQ;
   logic [WIDTH-1:0] dRdataQ;
   logic             busyQ;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) uPick (
      .ifReq      (bus.if_req),
      .dReq       (bus.d_req),
      .ifMask     (ifAckQ),
      .dMask      (dAckQ),
      .starveCnt  (starveCnt),
      .grantValid (grantValid),
      .grantId    (grantId)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         starveCnt <= '0;
         memReqQ   <= 1'b0;
         memWeQ    <= 1'b0;
         memAddrQ  <= '0;
         memWdataQ <= '0;
         ifAckQ    <= 1'b0;
         ifRdataQ  <= '0;
         dAckQ     <= 1'b0;
         dRdataQ   <= '0;
         busyQ     <= 1'b0;
      end else begin
         ifAckQ <= 1'b0;
         dAckQ  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!bus.if_req)
                  starveCnt <= '0;
               if (grantValid) begin
                  memReqQ <= 1'b1;
                  busyQ   <= 1'b1;
                  if (grantId == REQ_D) begin
                     memWeQ    <= bus.d_we;
                     memAddrQ  <= bus.d_addr;
                     memWdataQ <= bus.d_wdata;
                     state     <= ST_D_WAIT;
                     // Only a D grant that bypasses a waiting fetch counts.
                     if (bus.if_req)
                        starveCnt <= satInc(starveCnt, 4'(STARVE_MAX));
                  end else begin
                     memWeQ    <= 1'b0;
                     memAddrQ  <= bus.if_addr;
                     memWdataQ <= '0;
                     state     <= ST_IF_WAIT;
                     starveCnt <= '0;
                  end
               end
            end
            ST_IF_WAIT: begin
               if (bus.mem_ready) begin
                  memReqQ  <= 1'b0;
                  busyQ    <= 1'b0;
                  ifAckQ   <= 1'b1;
                  ifRdataQ <= bus.mem_rdata;
                  state    <= ST_IDLE;
               end
            end
            ST_D_WAIT: begin
               if (bus.mem_ready) begin
                  memReqQ <= 1'b0;
                  busyQ   <= 1'b0;
                  dAckQ   <= 1'b1;
                  // Stores leave the last load value in place.
                  if (!memWeQ)
                     dRdataQ <= bus.mem_rdata;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               memReqQ <= 1'b0;
               busyQ   <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req   = memReqQ;
   assign bus.mem_we    = memWeQ;
   assign bus.mem_addr  = memAddrQ;
   assign bus.mem_wdata = memWdataQ;
   assign bus.if_ack    = ifAckQ;
   assign bus.if_rdata  = ifRdataQ;
   assign bus.d_ack     = dAckQ;
   assign bus.d_rdata   = dRdataQ;
   assign bus.busy      = busyQ;
   assign bus.stall     = (bus.if_req & ~ifAckQ) | (bus.d_req & ~dAckQ);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// A transaction-level model predicts grants and acks per cycle.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic clk;
   logic reset;

   mem_port_arbiter_if #(.WIDTH(32)) bus ();

   mem_port_arbiter #(
      .WIDTH      (32),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          id;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          due;
   } memExpT;

   typedef struct {
      bit          id;
      logic [31:0] rdata;
      int          due;
   } ackExpT;

   memExpT memQ[$];
   ackExpT ackQ[$];
   memExpT cur;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit started = 0;
   bit prevMemReq = 0;

   int pIf = 0;
   int pD = 0;
   int pWe = 50;
   int maxLat = 2;
   bit ifActive = 0;
   bit dActive = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string nm);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d", nm, cyc);
   endtask

   // Reference model: which requester owns the port and what it returns.
   bit          mBusy = 0;
   bit          mOwner = 0;
   bit          mWe = 0;
   bit          mIfAck = 0;
   bit          mDAck = 0;
   int          starve = 0;
   logic [31:0] lastIf = '0;
   logic [31:0] lastD = '0;
   bit          ifLive;
   bit          dLive;
   bit          pickD;

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         mBusy  = 0;
         mIfAck = 0;
         mDAck  = 0;
         starve = 0;
         lastIf = '0;
         lastD  = '0;
         memQ.delete();
         ackQ.delete();
      end else if (!mBusy) begin
         ifLive = bus.if_req && !mIfAck;
         dLive  = bus.d_req && !mDAck;
         if (!bus.if_req) starve = 0;
         if (ifLive || dLive) begin
            pickD = dLive && !(ifLive && starve == SMAX);
            if (pickD) begin
               memQ.push_back('{1'b1, bus.d_we, bus.d_addr, bus.d_wdata, cyc});
               mWe = bus.d_we;
               if (bus.if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
            end else begin
               memQ.push_back('{1'b0, 1'b0, bus.if_addr, 32'h0, cyc});
               starve = 0;
            end
            mBusy  = 1;
            mOwner = pickD;
         end
         mIfAck = 0;
         mDAck  = 0;
      end else begin
         mIfAck = 0;
         mDAck  = 0;
         if (bus.mem_ready) begin
            if (mOwner) begin
               if (!mWe) lastD = bus.mem_rdata;
               ackQ.push_back('{1'b1, lastD, cyc});
               mDAck = 1;
            end else begin
               lastIf = bus.mem_rdata;
               ackQ.push_back('{1'b0, lastIf, cyc});
               mIfAck = 1;
            end
            mBusy = 0;
         end
      end
   end

   task automatic popAck(input bit id, input logic [31:0] rd);
      ackExpT e;
      if (ackQ.size() == 0) begin
         failNow(id ? "d_ack_unexpected" : "if_ack_unexpected");
      end else begin
         e = ackQ.pop_front();
         chk("ack_id", 32'(id), 32'(e.id));
         chk("ack_cycle", cyc, e.due);
         chk(id ? "d_rdata" : "if_rdata", rd, e.rdata);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queues.
   always @(negedge clk) begin
      if (started) begin
         chk("busy", 32'(bus.busy), 32'(mBusy));
         chk("stall", 32'(bus.stall),
             32'((bus.if_req & ~mIfAck) | (bus.d_req & ~mDAck)));
         if (bus.mem_req && !prevMemReq) begin
            if (memQ.size() == 0) begin
               failNow("mem_req_unexpected");
            end else begin
               cur = memQ.pop_front();
               chk("grant_cycle", cyc, cur.due);
               chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
               chk("mem_addr", bus.mem_addr, cur.addr);
               chk("mem_wdata", bus.mem_wdata, cur.wdata);
            end
         end else if (bus.mem_req) begin
            chk("hold_we", 32'(bus.mem_we), 32'(cur.we));
            chk("hold_addr", bus.mem_addr, cur.addr);
            chk("hold_wdata", bus.mem_wdata, cur.wdata);
         end
         if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            failNow("mem_req_missing");
            void'(memQ.pop_front());
         end
         if (bus.if_ack) popAck(1'b0, bus.if_rdata);
         if (bus.d_ack) popAck(1'b1, bus.d_rdata);
         if (ackQ.size() > 0 && ackQ[0].due <= cyc) begin
            failNow("ack_missing");
            void'(ackQ.pop_front());
         end
         prevMemReq = bus.mem_req;
      end
   end

   // Fetch requester: holds until acked, may reissue in the ack cycle.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (ifActive && bus.if_ack) ifActive = 0;
         if (!ifActive) begin
            if ($urandom_range(0, 99) < pIf) begin
               ifActive    = 1;
               bus.if_req  = 1'b1;
               bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end else begin
               bus.if_req = 1'b0;
            end
         end
      end
   end

   // Load/store requester.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (dActive && bus.d_ack) dActive = 0;
         if (!dActive) begin
            if ($urandom_range(0, 99) < pD) begin
               dActive     = 1;
               bus.d_req   = 1'b1;
               bus.d_we    = ($urandom_range(0, 99) < pWe);
               bus.d_addr  = $urandom;
               bus.d_wdata = $urandom;
            end else begin
               bus.d_req = 1'b0;
            end
         end
      end
   end

   // Memory responder with random latency; noise on ready when idle.
   bit memActive = 0;
   int waitLeft = 0;
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (bus.mem_req) begin
            if (!memActive) begin
               memActive = 1;
               waitLeft  = $urandom_range(0, maxLat);
            end
            if (waitLeft == 0) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = $urandom;
            end else begin
               bus.mem_ready = 1'b0;
               waitLeft--;
            end
         end else begin
            memActive     = 0;
            bus.mem_ready = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
         end
      end
   end

   task automatic runPhase(input int pi, input int pd, input int pw,
                           input int lat, input int n);
      pIf = pi;
      pD = pd;
      pWe = pw;
      maxLat = lat;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit seen;
      reset         = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_if_ack", 32'(bus.if_ack), 32'h0);
      chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      started = 1;
      #1 reset = 1'b1;

      runPhase(30, 0, 50, 1, 150);
      runPhase(0, 30, 50, 2, 150);
      runPhase(40, 40, 50, 3, 400);
      runPhase(100, 100, 30, 0, 300);
      runPhase(100, 100, 70, 3, 300);
      runPhase(20, 60, 50, 1, 300);

      pIf = 60;
      pD = 80;
      maxLat = 4;
      for (int r = 0; r < 8; r++) begin
         seen = 0;
         for (int w = 0; w < 50 && !seen; w++) begin
            @(negedge clk);
            seen = bus.busy;
         end
         if (!seen) failNow("busy_timeout");
         #1 reset = 1'b0;
         @(negedge clk);
         #1 reset = 1'b1;
         repeat ($urandom_range(3, 12)) @(negedge clk);
      end

      pIf = 0;
      pD = 0;
      seen = 0;
      for (int w = 0; w < 100 && !seen; w++) begin
         @(negedge clk);
         seen = !ifActive && !dActive && !bus.busy;
      end
      if (!seen) failNow("drain_timeout");
      repeat (3) @(negedge clk);
      chk("memQ_empty", 32'(memQ.size()), 32'h0);
      chk("ackQ_empty", 32'(ackQ.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (IF) and load/store data (D).
- Sits between the PC logic / fetch path, the load/store path, and the single memory that replaces separate instruction and data memories.
- Grants one transaction at a time and holds the memory handshake until the memory is ready.
- Returns read data with a one-cycle ack and drives a stall signal to the processor control.

Parameters:
WIDTH, 32, address/data width in bits
STARVE_MAX, 4, max consecutive D grants while IF is pending before IF is forced (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  WIDTH  fetch address
if_rdata  out  WIDTH  fetched word, valid only when if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  store data
d_rdata  out  WIDTH  load data, valid only when d_ack=1 and d_we=0
d_ack  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, held until mem_ready sampled high
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion; may be high in the first mem_req cycle
stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational
busy  out  1  1 when the state is not IDLE

Behaviour:
- States: IDLE, IF_WAIT, D_WAIT. All outputs are registered except stall.
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All registered outputs (mem_*, if_*, d_*, busy) go to 0.
  - Starve counter goes to 0.
  - An in-flight transaction is abandoned without an ack; the memory must tolerate mem_req dropping.
- IDLE:
  - Requests are evaluated. A requester whose ack is high this cycle is masked, so a stale req is never re-granted.
  - Priority: D over IF, except when starve_cnt == STARVE_MAX and if_req=1, in which case IF wins.
  - On a grant, mem_req/mem_we/mem_addr/mem_wdata are registered from the winner (mem_we=0, mem_wdata=0 for IF).
  - The state moves to IF_WAIT or D_WAIT.
- X_WAIT:
  - mem_* are held constant.
  - On mem_ready=1: mem_req drops, X_ack=1 and X_rdata=mem_rdata are registered, and the state returns to IDLE.
  - The rdata register holds its value until the next ack for that requester.
- Latency: request seen in IDLE at cycle 0 -> mem_req high at cycle 1 -> mem_ready at cycle k≥1 -> ack at cycle k+1 (minimum 2 cycles).
  - The ack cycle is also an IDLE evaluation cycle, so a pending other requester gets mem_req at cycle k+2.
- Starve counter (4 bits):
  - Increments on each D grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Clears when if_req=0 in IDLE.
- Simultaneous if_req and d_req with counter < STARVE_MAX: D is granted, and IF waits with stall=1.
- d_req with d_we=1 returns d_ack; d_rdata is undefined-but-stable (previous value retained).
- A requester dropping req before ack is a protocol violation; the in-flight transaction still completes and acks.
- Address/data width: pass-through, no alignment checks.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_IF_WAIT=2'd1, ST_D_WAIT=2'd2;
  - defaults WIDTH=32 and STARVE_MAX=4;
  - requester ID constants REQ_IF=1'b0, REQ_D=1'b1.
- One natural sub-module: mem_arb_pick. It is combinational; given if_req, d_req, the ack masks and starve_cnt, it outputs grant_valid and grant_id. Unit-testable on its own.

Test Plan:
- Reset, then a single fetch: if_req=1, if_addr=0x00000040, memory ready 1 cycle after mem_req with 0x8C220004 -> mem_req at cycle 1, if_ack=1 with if_rdata=0x8C220004 at cycle 2, stall=1 in cycles 0-1 and 0 at cycle 2.
- Simultaneous if_req (addr 0x44) and d_req load (addr 0x1000), 3-cycle memory -> D served first, d_ack at cycle 4; IF mem_req starts at cycle 5 with mem_addr=0x44, if_ack at cycle 8.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_ready; d_ack pulses; d_rdata unchanged.
- Starvation: if_req held, d_req re-asserted every cycle after each ack, STARVE_MAX=4 -> exactly 4 D grants, then an IF grant, counter returns to 0, D resumes.
- Reset mid-transaction: reset=0 while in D_WAIT with mem_ready=0 -> next cycle mem_req=0, d_ack=0, busy=0; after release, the held d_req is re-granted from IDLE.
- Back-to-back same requester: if_req kept high with a new if_addr=0x48 in the cycle after if_ack -> if_ack cycle is not re-granted (masked); the new fetch is granted the following cycle.
